common_issue_queue: RTL
=======================

COMMON_ISSUE_QUEUE -- requirements
Module: common_issue_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries (power of two, 2..16).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 dispatch_en  input  1  push request from the dispatch generator (mult or div enable).
REQ-006 i_fifo_data  input  common_fifo_data  entry to push: rs1/rs2 data, rs1/rs2 tags, rd_tag, rs1/rs2 valid.
REQ-007 cdb_valid  input  1  common data bus broadcast valid.
REQ-008 cdb_tag  input  6  tag being broadcast.
REQ-009 cdb_data  input  32  value being broadcast.
REQ-010 flush  input  1  discard all entries (mispredict recovery).
REQ-011 exec_ready  input  1  downstream execution unit accepts an issue this cycle.
REQ-012 issue_valid  output  1  head entry is valid with both operands ready.
REQ-013 o_issue_data  output  common_fifo_data  head entry contents, operands resolved.
REQ-014 queue_full  output  1  no free entry; dispatch must stall.
REQ-015 queue_count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 Push: dispatch_en=1 and queue_full=0 SHALL write i_fifo_data at tail and advance tail at the clock edge.
REQ-018 A push while queue_full=1 SHALL be ignored with no state change; queue_full SHALL be count==DEPTH from registered state, not relieved by a same-cycle pop.
REQ-019 Issue: issue_valid SHALL be combinational: count!=0 AND head rs1_data_valid AND head rs2_data_valid.
REQ-020 Pop: issue_valid=1 and exec_ready=1 SHALL advance head at the clock edge; issue is strictly in order, head only.
REQ-021 Simultaneous push and pop when not full SHALL leave count unchanged and perform both.
REQ-022 Wakeup: on cdb_valid=1, every occupied entry with rsX_data_valid=0 and rsX_tag==cdb_tag SHALL capture cdb_data into rsX_data and set rsX_data_valid, independently for rs1 and rs2.
REQ-023 An entry being pushed in the same cycle as a matching CDB broadcast SHALL be written with the captured value and its valid bit set.
REQ-024 Entries already marked valid SHALL NOT be overwritten by a CDB match.
REQ-025 Wakeup SHALL take effect from the next cycle: a CDB broadcast in cycle N makes the head issuable no earlier than N+1; there is no combinational CDB bypass to o_issue_data.
REQ-026 Minimum push-to-issue latency SHALL be 1 cycle: a ready entry pushed into an empty queue at edge N has issue_valid=1 in cycle N+1.
REQ-027 flush=1 SHALL zero head, tail and count and invalidate all entries at the edge, taking priority over a same-cycle push, pop and wakeup.
REQ-028 o_issue_data SHALL be the head slot contents whenever count!=0; its value is don't-care when count==0.
REQ-029 rd_tag SHALL pass through unmodified from push to issue.

Reset
REQ-030 rst=1 SHALL set head=0, tail=0, count=0 and clear all entry valid bits; in the cycle after the reset edge issue_valid=0, queue_full=0 and queue_count=0.
REQ-031 rst SHALL override flush, push, pop and wakeup; reset in the middle of operation drops all entries.
REQ-032 Entry data fields need not be reset.

Structure
REQ-033 common_fifo_data SHALL remain the shared typedef in the common package (utils.sv); the queue SHALL NOT redefine it.
REQ-034 The CDB tag width (6) and data width (32) SHALL be package constants shared with dispatch_gen.
REQ-035 The per-entry operand snoop (tag compare, capture, valid set) SHALL be one sub-module, cdb_snoop_entry, instantiated DEPTH+1 times (DEPTH entries plus the incoming push).
REQ-036 The same module SHALL be instantiated separately for the mult and div paths.

Verification
REQ-037 Push one entry with both operands valid (rs1=5, rs2=7, rd_tag=3) into an empty queue, exec_ready=1 -> issue_valid=1 the next cycle with rs1_data=5, rs2_data=7, rd_tag=3; count returns to 0.
REQ-038 Push an entry with rs1 valid=0, rs1_tag=12; later cdb_valid=1, cdb_tag=12, cdb_data=0xDEADBEEF -> issue_valid=1 one cycle after the broadcast, rs1_data=0xDEADBEEF.
REQ-039 Push 4 entries with exec_ready=0 -> queue_full=1, count=4; a 5th push is ignored; pop one -> queue_full=0 the following cycle.
REQ-040 A push with rs2_tag=9 in the same cycle as cdb_tag=9, cdb_data=0x55 -> the stored entry has rs2_data=0x55 and valid=1.
REQ-041 Head not ready (tag 4) while entry 2 is ready -> no issue until tag 4 is broadcast; then issue order is entry 1, then entry 2.
REQ-042 With 3 entries, wrap tail past DEPTH-1 and then assert flush (or rst) together with a push -> count=0, issue_valid=0 next cycle, and the push is dropped.

Source files
------------

// File: rtl/common_issue_queue_pkg.sv
// common_issue_queue_pkg: shared CDB widths and the dispatch/issue entry type
package common_issue_queue_pkg;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    data_t rs1_data;
    data_t rs2_data;
    tag_t rs1_tag;
    tag_t rs2_tag;
    tag_t rd_tag;
    logic rs1_data_valid;
    logic rs2_data_valid;
  } common_fifo_data;
endpackage

// File: rtl/common_issue_queue_if.sv
// common_issue_queue_if: dispatch, CDB and issue signals of one issue queue
interface common_issue_queue_if #(parameter int DEPTH = 4);
  import common_issue_queue_pkg::*;
  logic dispatch_en;
  common_fifo_data i_fifo_data;
  logic cdb_valid;
  tag_t cdb_tag;
  data_t cdb_data;
  logic flush;
  logic exec_ready;
  logic issue_valid;
  common_fifo_data o_issue_data;
  logic queue_full;
  logic [$clog2(DEPTH):0] queue_count;
  modport master (
    output dispatch_en, i_fifo_data, cdb_valid, cdb_tag, cdb_data, flush, exec_ready,
    input issue_valid, o_issue_data, queue_full, queue_count
  );
  modport slave (
    input dispatch_en, i_fifo_data, cdb_valid, cdb_tag, cdb_data, flush, exec_ready,
    output issue_valid, o_issue_data, queue_full, queue_count
  );
endinterface

// File: rtl/common_issue_queue_snoop.sv
// cdb_snoop_entry: captures a CDB broadcast into any still-waiting operand of one entry
module cdb_snoop_entry
  import common_issue_queue_pkg::*;
(
  input logic cdb_valid,
  input tag_t cdb_tag,
  input data_t cdb_data,
  input common_fifo_data entry_in,
  output common_fifo_data entry_out
);
  logic hit1, hit2;
  assign hit1 = cdb_valid && !entry_in.rs1_data_valid && entry_in.rs1_tag == cdb_tag;
  assign hit2 = cdb_valid && !entry_in.rs2_data_valid && entry_in.rs2_tag == cdb_tag;
  always_comb begin
    entry_out = entry_in;
    entry_out.rs1_data = hit1 ? cdb_data : entry_in.rs1_data;
    entry_out.rs2_data = hit2 ? cdb_data : entry_in.rs2_data;
    entry_out.rs1_data_valid = entry_in.rs1_data_valid || hit1;
    entry_out.rs2_data_valid = entry_in.rs2_data_valid || hit2;
  end
endmodule

// File: rtl/common_issue_queue.sv
// common_issue_queue: in-order issue queue with CDB operand wakeup for one execution path
module common_issue_queue
  import common_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  common_issue_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] occ;
  logic push, pop;
  common_fifo_data mem [DEPTH];
  common_fifo_data snoop [DEPTH];
  common_fifo_data push_entry;
  assign q.queue_full = count == CW'(DEPTH);
  assign push = q.dispatch_en && !q.queue_full;
  assign q.issue_valid = count != '0 && mem[head].rs1_data_valid && mem[head].rs2_data_valid;
  assign pop = q.issue_valid && q.exec_ready;
  assign q.o_issue_data = mem[head];
  assign q.queue_count = count;
  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    cdb_snoop_entry u_snoop (
      .cdb_valid(q.cdb_valid),
      .cdb_tag(q.cdb_tag),
      .cdb_data(q.cdb_data),
      .entry_in(mem[i]),
      .entry_out(snoop[i])
    );
  end
  // The incoming push snoops too, so a same-cycle broadcast is never missed
  cdb_snoop_entry u_push_snoop (
    .cdb_valid(q.cdb_valid),
    .cdb_tag(q.cdb_tag),
    .cdb_data(q.cdb_data),
    .entry_in(q.i_fifo_data),
    .entry_out(push_entry)
  );
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      occ <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
      occ <= (occ & ~(DEPTH'(pop) << head)) | (DEPTH'(push) << tail);
    end
  end
  // Data fields carry no reset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (occ[i]) mem[i] <= snoop[i];
    if (push) mem[tail] <= push_entry;
  end
endmodule
